// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: registers ALU results into a 2-entry skid buffer and resolves branches at capture.
// Optional BRANCH_STATS_EN adds stat_branches/stat_taken counters.
module alu_writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_less,
    input  logic                  alu_greater,
    input  logic [2:0]            branch_type,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     imm_offset,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     result_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  flush,
    output logic [DATA_W-1:0]     branch_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_taken
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     target;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  taken;
        logic                  isBranch;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t inEntry;
    logic   acc;
    logic   pop;
    logic   takenIn;

    // Branch resolution happens once, at capture; stored entries never see later flag changes.
    always_comb begin
        takenIn = 1'b0;
        case (branch_type)
            3'b001:  takenIn = alu_zero;
            3'b010:  takenIn = !alu_zero;
            3'b011:  takenIn = alu_less;
            3'b100:  takenIn = alu_greater;
            3'b101:  takenIn = alu_greater | (!alu_less & !alu_greater);
            3'b110:  takenIn = 1'b1;
            default: takenIn = 1'b0;
        endcase
    end

    always_comb begin
        inEntry          = '0;
        inEntry.result   = alu_result;
        inEntry.target   = pc_in + imm_offset;
        inEntry.rd       = rd_in;
        inEntry.regWrite = reg_write_in;
        inEntry.taken    = takenIn;
        inEntry.isBranch = (branch_type != 3'b000) && (branch_type != 3'b111);
    end

    assign in_ready      = (state_q != TWO);
    assign out_valid     = (state_q != EMPTY);
    assign acc           = in_valid & in_ready;
    assign pop           = out_valid & out_ready;
    assign flush         = pop & head_q.taken & !rst;
    assign result_out    = head_q.result;
    assign rd_out        = head_q.rd;
    assign reg_write_out = out_valid & head_q.regWrite;
    assign branch_target = head_q.target;

    // A taken branch leaving the head squashes everything behind it (skid and same-cycle input).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    head_d  = inEntry;
                end
            end
            ONE: begin
                if (pop && head_q.taken) begin
                    state_d = EMPTY;
                end else if (acc && pop) begin
                    head_d = inEntry;
                end else if (acc) begin
                    state_d = TWO;
                    skid_d  = inEntry;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop && head_q.taken) begin
                    state_d = EMPTY;
                end else if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] statBranches_q;
    logic [31:0] statTaken_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            statBranches_q <= '0;
            statTaken_q    <= '0;
        end else begin
            if (pop && head_q.isBranch) statBranches_q <= statBranches_q + 32'd1;
            if (flush)                  statTaken_q    <= statTaken_q + 32'd1;
        end
    end

    assign stat_branches = statBranches_q;
    assign stat_taken    = statTaken_q;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage; stat counter checks compile in with BRANCH_STATS_EN.
module tb_alu_writeback_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_less;
    logic        alu_greater;
    logic [2:0]  branch_type;
    logic [31:0] pc_in;
    logic [31:0] imm_offset;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        flush;
    logic [31:0] branch_target;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
`endif

    int nChecks = 0;
    int nFails  = 0;

    alu_writeback_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_less      (alu_less),
        .alu_greater   (alu_greater),
        .branch_type   (branch_type),
        .pc_in         (pc_in),
        .imm_offset    (imm_offset),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_out    (result_out),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .flush         (flush),
        .branch_target (branch_target)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic v, input logic [31:0] res, input logic [2:0] bt,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                         input logic wr, input logic z, input logic l, input logic g);
        in_valid     = v;
        alu_result   = res;
        branch_type  = bt;
        pc_in        = pc;
        imm_offset   = imm;
        rd_in        = rd;
        reg_write_in = wr;
        alu_zero     = z;
        alu_less     = l;
        alu_greater  = g;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        setIn(1'b1, 32'h99, 3'b110, 32'h0, 32'h4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            nChecks++;
            if ({out_valid, flush, reg_write_out} !== 3'b000) begin
                nFails++;
                $display("[TB] FAIL reset_hold got valid/flush/wr=%b required 000", {out_valid, flush, reg_write_out});
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        nChecks++;
        if ({in_ready, out_valid, flush, reg_write_out} !== 4'b1000) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl got rdy/valid/flush/wr=%b required 1000",
                     {in_ready, out_valid, flush, reg_write_out});
        end
        nChecks++;
        if ({result_out, rd_out, branch_target} !== 69'd0) begin
            nFails++;
            $display("[TB] FAIL reset_data got res=%h rd=%h tgt=%h required 0", result_out, rd_out, branch_target);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            setIn(1'b1, 32'(i), 3'b000, 32'h0, 32'h0, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            nChecks++;
            if ({out_valid, result_out, rd_out, reg_write_out, flush, in_ready} !== {1'b1, 32'(i), 5'(i), 1'b1, 1'b0, 1'b1}) begin
                nFails++;
                $display("[TB] FAIL stream_%0d got v=%b res=%h rd=%0d wr=%b fl=%b rdy=%b required v=1 res=%h rd=%0d wr=1 fl=0 rdy=1",
                         i, out_valid, result_out, rd_out, reg_write_out, flush, in_ready, i, i);
            end
        end
        in_valid = 1'b0;
        tick();
        nChecks++;
        if ({out_valid, reg_write_out} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL stream_drain got v/wr=%b required 00", {out_valid, reg_write_out});
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        setIn(1'b1, 32'hA, 3'b000, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        setIn(1'b1, 32'hB, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        nChecks++;
        if ({in_ready, out_valid, result_out} !== {1'b0, 1'b1, 32'hA}) begin
            nFails++;
            $display("[TB] FAIL stall_full got rdy=%b v=%b res=%h required rdy=0 v=1 res=a", in_ready, out_valid, result_out);
        end
        tick();
        nChecks++;
        if ({in_ready, out_valid, result_out, rd_out} !== {1'b0, 1'b1, 32'hA, 5'd1}) begin
            nFails++;
            $display("[TB] FAIL stall_hold got rdy=%b v=%b res=%h rd=%0d required rdy=0 v=1 res=a rd=1",
                     in_ready, out_valid, result_out, rd_out);
        end
        out_ready = 1'b1;
        tick();
        nChecks++;
        if ({out_valid, result_out, rd_out, in_ready} !== {1'b1, 32'hB, 5'd2, 1'b1}) begin
            nFails++;
            $display("[TB] FAIL stall_second got v=%b res=%h rd=%0d rdy=%b required v=1 res=b rd=2 rdy=1",
                     out_valid, result_out, rd_out, in_ready);
        end
        tick();
        nChecks++;
        if (out_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL stall_empty got v=%b required 0", out_valid);
        end
    endtask

    typedef struct {
        logic [2:0] bt;
        logic       z;
        logic       l;
        logic       g;
        logic       expTaken;
    } brVec_t;

    task automatic test_branches();
        brVec_t vecs[8];
        vecs[0] = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3'b011, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            setIn(1'b1, 32'(i), vecs[i].bt, 32'h100, 32'h20, 5'd4, 1'b0,
                  vecs[i].z, vecs[i].l, vecs[i].g);
            tick();
            in_valid = 1'b0;
            alu_zero = ~vecs[i].z;
            nChecks++;
            if ({out_valid, flush, branch_target} !== {1'b1, vecs[i].expTaken, 32'h120}) begin
                nFails++;
                $display("[TB] FAIL branch_%0d type=%b got v=%b flush=%b tgt=%h required v=1 flush=%b tgt=120",
                         i, vecs[i].bt, out_valid, flush, branch_target, vecs[i].expTaken);
            end
            tick();
            nChecks++;
            if ({out_valid, flush} !== 2'b00) begin
                nFails++;
                $display("[TB] FAIL branch_%0d_after got v/flush=%b required 00", i, {out_valid, flush});
            end
        end
    endtask

    task automatic test_wrong_path();
        out_ready = 1'b0;
        setIn(1'b1, 32'h11, 3'b110, 32'h200, 32'h40, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        setIn(1'b1, 32'h55, 3'b000, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        nChecks++;
        if ({flush, in_ready, out_valid} !== 3'b001) begin
            nFails++;
            $display("[TB] FAIL wrongpath_stalled got flush/rdy/v=%b required 001", {flush, in_ready, out_valid});
        end
        out_ready = 1'b1;
        #1;
        nChecks++;
        if ({flush, branch_target} !== {1'b1, 32'h240}) begin
            nFails++;
            $display("[TB] FAIL wrongpath_flush got flush=%b tgt=%h required flush=1 tgt=240", flush, branch_target);
        end
        tick();
        nChecks++;
        if ({out_valid, in_ready, flush} !== 3'b010) begin
            nFails++;
            $display("[TB] FAIL wrongpath_drop got v/rdy/flush=%b required 010", {out_valid, in_ready, flush});
        end
        tick();
        nChecks++;
        if (out_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL wrongpath_stay_empty got v=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        setIn(1'b1, 32'h21, 3'b110, 32'h300, 32'h8, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        setIn(1'b1, 32'h77, 3'b000, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if ({flush, branch_target} !== {1'b1, 32'h308}) begin
            nFails++;
            $display("[TB] FAIL b2b_flush got flush=%b tgt=%h required flush=1 tgt=308", flush, branch_target);
        end
        tick();
        in_valid = 1'b0;
        nChecks++;
        if (out_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_drop_input got v=%b res=%h required v=0", out_valid, result_out);
        end
        setIn(1'b1, 32'h31, 3'b001, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        setIn(1'b1, 32'h32, 3'b000, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        alu_zero = 1'b1;
        tick();
        in_valid = 1'b0;
        nChecks++;
        if ({out_valid, result_out, flush} !== {1'b1, 32'h32, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL b2b_nottaken got v=%b res=%h flush=%b required v=1 res=32 flush=0",
                     out_valid, result_out, flush);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        setIn(1'b1, 32'h41, 3'b110, 32'h0, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        setIn(1'b1, 32'h42, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        nChecks++;
        if (flush !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL resetmid_flush got flush=%b required 0", flush);
        end
        tick();
        rst = 1'b0;
        #1;
        nChecks++;
        if ({out_valid, in_ready, flush, result_out} !== {3'b010, 32'h0}) begin
            nFails++;
            $display("[TB] FAIL resetmid_empty got v/rdy/flush=%b res=%h required 010 res=0",
                     {out_valid, in_ready, flush}, result_out);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        setIn(1'b1, 32'h5, 3'b110, 32'hFFFF_FFF0, 32'h20, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        nChecks++;
        if ({flush, branch_target} !== {1'b1, 32'h0000_0010}) begin
            nFails++;
            $display("[TB] FAIL wrap_target got flush=%b tgt=%h required flush=1 tgt=00000010", flush, branch_target);
        end
        tick();
`ifdef BRANCH_STATS_EN
        nChecks++;
        if ({stat_taken, stat_branches} !== {32'd1, 32'd1}) begin
            nFails++;
            $display("[TB] FAIL wrap_stats got taken=%0d branches=%0d required 1 1", stat_taken, stat_branches);
        end
`endif
        nChecks++;
        if (out_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL wrap_after got v=%b required 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        setIn(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_stall();
        test_branches();
        test_wrong_path();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
